// File: rtl/booth_arbiter_if.sv
// rtl/booth_arbiter_if.sv - requester and multiplier signals shared by booth_arbiter and its neighbours
interface booth_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 6
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_m;
  logic [NREQ*WIDTH-1:0] req_q;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [2*WIDTH-1:0]    rsp_result;
  logic                  busy;
  logic [WIDTH-1:0]      mul_m;
  logic [WIDTH-1:0]      mul_q;
  logic                  mul_start;
  logic [2*WIDTH-1:0]    mul_result;

  modport slave (
    input  req, req_m, req_q, mul_result,
    output gnt, done, rsp_result, busy, mul_m, mul_q, mul_start
  );

  modport master (
    output req, req_m, req_q, mul_result,
    input  gnt, done, rsp_result, busy, mul_m, mul_q, mul_start
  );
endinterface

// File: rtl/booth_arbiter.sv
// rtl/booth_arbiter.sv - round-robin arbiter sharing one fixed-latency booth multiplier among NREQ requesters
module booth_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 6,
  parameter int MUL_LAT = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  booth_arbiter_if.slave   bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic               mul_start_q, mul_start_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   mul_m_q, mul_m_d;
  logic [WIDTH-1:0]   mul_q_q, mul_q_d;
  logic [2*WIDTH-1:0] rsp_q, rsp_d;

  logic [PW-1:0]      cand [NREQ];
  logic               found;
  logic [PW-1:0]      sel;

  // cand[k] is the requester examined k-th in the rotation starting at ptr
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      cand[k] = PW'((int'(ptr_q) + k) % NREQ);
    end
  end

  // Scanning from the far end lets the earliest candidate in the rotation win
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[cand[k]]) begin
        found = 1'b1;
        sel   = cand[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    done_d      = '0;
    mul_start_d = 1'b0;
    busy_d      = busy_q;
    mul_m_d     = mul_m_q;
    mul_q_d     = mul_q_q;
    rsp_d       = rsp_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d[sel]  = 1'b1;
          mul_start_d = 1'b1;
          mul_m_d     = bus.req_m[int'(sel)*WIDTH +: WIDTH];
          mul_q_d     = bus.req_q[int'(sel)*WIDTH +: WIDTH];
          owner_d     = sel;
          cnt_d       = CW'(MUL_LAT);
          busy_d      = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // cnt reaches 0 in the cycle the multiplier result becomes valid
        if (cnt_q == '0) begin
          rsp_d           = bus.mul_result;
          done_d[owner_q] = 1'b1;
          busy_d          = 1'b0;
          ptr_d           = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          state_d         = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
      mul_m_q     <= '0;
      mul_q_q     <= '0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
      mul_m_q     <= mul_m_d;
      mul_q_q     <= mul_q_d;
      rsp_q       <= rsp_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.mul_start  = mul_start_q;
  assign bus.busy       = busy_q;
  assign bus.mul_m      = mul_m_q;
  assign bus.mul_q      = mul_q_q;
  assign bus.rsp_result = rsp_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// tb/tb_booth_arbiter.sv - scoreboard bench for booth_arbiter with fixed-latency multiplier models
module tb_booth_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 6;
  localparam int LAT   = 8;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  booth_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus_a ();
  booth_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus_b ();

  booth_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MUL_LAT(LAT)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(bus_a.slave)
  );
  booth_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MUL_LAT(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(bus_b.slave)
  );

  function automatic logic [11:0] smul(input logic [5:0] a, input logic [5:0] b);
    return $signed({{6{a[5]}}, a}) * $signed({{6{b[5]}}, b});
  endfunction

  // Multiplier models: product is only valid exactly MUL_LAT cycles after the start cycle
  logic [3:0]  lat_a, lat_b;
  logic [11:0] prod_a, prod_b;
  always @(posedge clk) begin
    if (!n_rst) lat_a <= '0;
    else if (bus_a.mul_start) begin
      lat_a  <= 4'(LAT);
      prod_a <= smul(bus_a.mul_m, bus_a.mul_q);
    end else if (lat_a != 0) lat_a <= lat_a - 4'd1;
  end
  always @(posedge clk) begin
    if (!n_rst) lat_b <= '0;
    else if (bus_b.mul_start) begin
      lat_b  <= 4'd1;
      prod_b <= smul(bus_b.mul_m, bus_b.mul_q);
    end else if (lat_b != 0) lat_b <= lat_b - 4'd1;
  end
  assign bus_a.mul_result = (lat_a == 4'd1) ? prod_a : 12'hBAD;
  assign bus_b.mul_result = (lat_b == 4'd1) ? prod_b : 12'hBAD;

  typedef struct {
    int          idx;
    logic [11:0] prod;
  } exp_t;

  exp_t        exp_q[$];
  int          gnt_idx_q[$];
  int          gnt_cyc_q[$];
  int          start_cnt = 0;
  logic [3:0]  drop_a    = 4'b1111;

  // Advance one cycle; observe DUT A outputs at the falling edge and model requester drop-after-grant
  task automatic tick();
    exp_t       e;
    logic [3:0] exp_done;
    @(negedge clk);
    cyc++;
    if (bus_a.mul_start) start_cnt++;
    for (int i = 0; i < NREQ; i++) begin
      if (bus_a.gnt[i]) begin
        gnt_idx_q.push_back(i);
        gnt_cyc_q.push_back(cyc);
      end
    end
    if (|bus_a.done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done=%b rsp_result=%h, required no done", bus_a.done, bus_a.rsp_result);
      end else begin
        e = exp_q.pop_front();
        exp_done = '0;
        exp_done[e.idx] = 1'b1;
        checks++;
        if (bus_a.done !== exp_done) begin
          errors++;
          $display("FAIL done_owner: done=%b required %b", bus_a.done, exp_done);
        end
        checks++;
        if (bus_a.rsp_result !== e.prod) begin
          errors++;
          $display("FAIL rsp_result: got %h required %h (requester %0d)", bus_a.rsp_result, e.prod, e.idx);
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus_a.gnt[i] && drop_a[i]) bus_a.req[i] = 1'b0;
    end
  endtask

  task automatic set_ops(input int i, input logic [5:0] m, input logic [5:0] q);
    bus_a.req_m[i*WIDTH +: WIDTH] = m;
    bus_a.req_q[i*WIDTH +: WIDTH] = q;
  endtask

  task automatic wait_gnt_a();
    int n = 0;
    tick();
    while (!(|bus_a.gnt) && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus_a.req = 4'($urandom_range(1, 15));
    for (int i = 0; i < NREQ; i++) set_ops(i, 6'($urandom), 6'($urandom));
    tick();
    tick();
    checks++;
    if ({bus_a.gnt, bus_a.done, bus_a.mul_start, bus_a.busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b done=%b start=%b busy=%b, required all 0",
               bus_a.gnt, bus_a.done, bus_a.mul_start, bus_a.busy);
    end
    checks++;
    if ({bus_a.mul_m, bus_a.mul_q, bus_a.rsp_result} !== 24'b0) begin
      errors++;
      $display("FAIL reset_data: mul_m=%h mul_q=%h rsp=%h, required 0", bus_a.mul_m, bus_a.mul_q, bus_a.rsp_result);
    end
    set_ops(1, 6'd9, -6'sd7);
    set_ops(3, 6'd4, 6'd4);
    bus_a.req = 4'b1010;
    gnt_idx_q.delete();
    exp_q.push_back('{idx: 1, prod: smul(6'd9, -6'sd7)});
    n_rst = 1'b1;
    wait_gnt_a();
    checks++;
    if (bus_a.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL reset_first_gnt: gnt=%b required 0010", bus_a.gnt);
    end
    bus_a.req = 4'b0000;
    drain("reset");
  endtask

  task automatic test_single_op();
    int s;
    int bad = 0;
    int n = 0;
    set_ops(0, 6'b110100, 6'b011110);
    exp_q.push_back('{idx: 0, prod: 12'hE98});
    gnt_idx_q.delete();
    start_cnt = 0;
    bus_a.req = 4'b0001;
    wait_gnt_a();
    s = cyc;
    checks++;
    if ({bus_a.gnt, bus_a.mul_start} !== 5'b00011) begin
      errors++;
      $display("FAIL single_gnt_start: gnt=%b start=%b, required 0001 and 1", bus_a.gnt, bus_a.mul_start);
    end
    while (!(|bus_a.done) && n < 40) begin
      tick();
      n++;
      if (!(|bus_a.done) && (bus_a.mul_m !== 6'b110100 || bus_a.mul_q !== 6'b011110 || bus_a.busy !== 1'b1))
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_hold: %0d cycles with operands or busy disturbed, required 0", bad);
    end
    checks++;
    if (cyc - s != LAT + 1) begin
      errors++;
      $display("FAIL single_latency: done %0d cycles after start, required %0d", cyc - s, LAT + 1);
    end
    checks++;
    if (start_cnt != 1 || gnt_idx_q.size() != 1) begin
      errors++;
      $display("FAIL single_pulses: starts=%0d grants=%0d, required 1 and 1", start_cnt, gnt_idx_q.size());
    end
    repeat (3) tick();
    checks++;
    if (bus_a.rsp_result !== 12'hE98 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp_hold: rsp=%h busy=%b, required E98 and 0", bus_a.rsp_result, bus_a.busy);
    end
    drain("single");
  endtask

  task automatic test_contention();
    n_rst = 1'b0;
    tick();
    set_ops(0, 6'd1, 6'd1);
    set_ops(1, 6'd2, -6'sd3);
    set_ops(2, 6'b100000, 6'b100000);
    set_ops(3, 6'd31, 6'b111111);
    exp_q.push_back('{idx: 0, prod: 12'h001});
    exp_q.push_back('{idx: 1, prod: 12'hFFA});
    exp_q.push_back('{idx: 2, prod: 12'h400});
    exp_q.push_back('{idx: 3, prod: 12'hFE1});
    gnt_idx_q.delete();
    gnt_cyc_q.delete();
    bus_a.req = 4'b1111;
    n_rst = 1'b1;
    drain("contention");
    checks++;
    if (gnt_idx_q.size() != 4) begin
      errors++;
      $display("FAIL contention_count: %0d grants, required 4", gnt_idx_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gnt_idx_q[k] != k) begin
          errors++;
          $display("FAIL contention_order[%0d]: granted %0d, required %0d", k, gnt_idx_q[k], k);
        end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (gnt_cyc_q[k] - gnt_cyc_q[k-1] != LAT + 2) begin
          errors++;
          $display("FAIL contention_spacing[%0d]: %0d cycles, required %0d", k, gnt_cyc_q[k] - gnt_cyc_q[k-1], LAT + 2);
        end
      end
    end
  endtask

  task automatic test_rr_wrap();
    int order [5] = '{3, 1, 3, 1, 3};
    int n = 0;
    drop_a = 4'b0101;
    set_ops(3, 6'd5, 6'd6);
    set_ops(1, -6'sd4, 6'd3);
    for (int k = 0; k < 5; k++) exp_q.push_back('{idx: order[k], prod: (order[k] == 3) ? 12'd30 : 12'hFF4});
    gnt_idx_q.delete();
    bus_a.req = 4'b1000;
    wait_gnt_a();
    bus_a.req[1] = 1'b1;
    while (gnt_idx_q.size() < 5 && n < 200) begin
      tick();
      n++;
    end
    bus_a.req = 4'b0000;
    drop_a = 4'b1111;
    drain("rr");
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= gnt_idx_q.size() || gnt_idx_q[k] != order[k]) begin
        errors++;
        $display("FAIL rr_order[%0d]: granted %0d, required %0d", k,
                 (k < gnt_idx_q.size()) ? gnt_idx_q[k] : -1, order[k]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    set_ops(1, 6'd7, -6'sd8);
    set_ops(3, -6'sd9, 6'd10);
    exp_q.push_back('{idx: 1, prod: smul(6'd7, -6'sd8)});
    bus_a.req = 4'b0010;
    drain("riw_prep");
    bus_a.req = 4'b0010;
    wait_gnt_a();
    repeat (4) tick();
    n_rst = 1'b0;
    tick();
    checks++;
    if ({bus_a.busy, bus_a.done, bus_a.gnt, bus_a.mul_start} !== 10'b0) begin
      errors++;
      $display("FAIL riw_abort: busy=%b done=%b gnt=%b start=%b, required all 0",
               bus_a.busy, bus_a.done, bus_a.gnt, bus_a.mul_start);
    end
    bus_a.req = 4'b1010;
    exp_q.push_back('{idx: 1, prod: smul(6'd7, -6'sd8)});
    n_rst = 1'b1;
    wait_gnt_a();
    checks++;
    if (bus_a.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL riw_regrant: gnt=%b required 0010", bus_a.gnt);
    end
    bus_a.req = 4'b0000;
    drain("riw");
  endtask

  task automatic test_late_request();
    int n = 0;
    set_ops(0, 6'b111111, 6'b111111);
    set_ops(2, 6'd12, -6'sd11);
    exp_q.push_back('{idx: 0, prod: 12'h001});
    exp_q.push_back('{idx: 2, prod: smul(6'd12, -6'sd11)});
    gnt_idx_q.delete();
    bus_a.req = 4'b0001;
    wait_gnt_a();
    tick();
    tick();
    bus_a.req[2] = 1'b1;
    while (!(|bus_a.done) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (gnt_idx_q.size() != 1) begin
      errors++;
      $display("FAIL late_no_gnt_busy: %0d grants by done, required 1", gnt_idx_q.size());
    end
    tick();
    checks++;
    if (bus_a.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL late_next_gnt: gnt=%b one cycle after done, required 0100", bus_a.gnt);
    end
    drain("late");
  endtask

  task automatic test_min_latency();
    int s;
    int n = 0;
    bus_b.req_m[1*WIDTH +: WIDTH] = -6'sd5;
    bus_b.req_q[1*WIDTH +: WIDTH] = 6'd7;
    bus_b.req = 4'b0010;
    tick();
    while (!(|bus_b.gnt) && n < 20) begin
      tick();
      n++;
    end
    s = cyc;
    checks++;
    if ({bus_b.gnt, bus_b.mul_start} !== 5'b00101) begin
      errors++;
      $display("FAIL minlat_gnt: gnt=%b start=%b, required 0010 and 1", bus_b.gnt, bus_b.mul_start);
    end
    n = 0;
    tick();
    while (!(|bus_b.done) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (cyc - s != 2 || bus_b.done !== 4'b0010 || bus_b.rsp_result !== 12'hFDD) begin
      errors++;
      $display("FAIL minlat_done: delay=%0d done=%b rsp=%h, required 2, 0010, FDD",
               cyc - s, bus_b.done, bus_b.rsp_result);
    end
    tick();
    checks++;
    if (bus_b.gnt !== 4'b0010 || cyc - s != 3) begin
      errors++;
      $display("FAIL minlat_regrant: gnt=%b at +%0d, required 0010 at +3", bus_b.gnt, cyc - s);
    end
    bus_b.req = 4'b0000;
    repeat (2) tick();
    checks++;
    if (bus_b.done !== 4'b0010 || bus_b.rsp_result !== 12'hFDD) begin
      errors++;
      $display("FAIL minlat_second: done=%b rsp=%h, required 0010 and FDD", bus_b.done, bus_b.rsp_result);
    end
  endtask

  initial begin
    bus_a.req   = '0;
    bus_a.req_m = '0;
    bus_a.req_q = '0;
    bus_b.req   = '0;
    bus_b.req_m = '0;
    bus_b.req_q = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_rr_wrap();
    test_reset_in_wait();
    test_late_request();
    test_min_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/booth_arbiter.md
Name: booth_arbiter

Overview:
Round-robin arbiter and sequencer that shares one booth multiplier instance among NREQ requesters. It accepts operand pairs (M, Q) from requesters and issues a one-cycle start pulse to the multiplier. It times the multiplier latency with an internal counter, then returns the 2*WIDTH-bit product to the owning requester with a done pulse. It sits between the requesting datapath blocks and the booth multiplier. It drives the multiplier's M, Q and start inputs and reads its result output.

Parameters:
NREQ, 4, number of requesters (>=2).
WIDTH, 6, operand width; signed two's complement.
MUL_LAT, 8, cycles from the multiplier start cycle to a valid multiplier result (>=1). Must match the attached booth instance.

Ports:
clk  input  1  clock, rising edge.
n_rst  input  1  reset, synchronous, active-low.
req  input  NREQ  per-requester request level; operands are held stable while high.
req_m  input  NREQ*WIDTH  multiplicand; requester i uses bits [i*WIDTH +: WIDTH].
req_q  input  NREQ*WIDTH  multiplier; same packing as req_m.
gnt  output  NREQ  one-hot, one-cycle accept pulse.
done  output  NREQ  one-hot, one-cycle completion pulse.
rsp_result  output  2*WIDTH  product for the requester flagged by done.
busy  output  1  high while an operation is in flight.
mul_m  output  WIDTH  operand M to the multiplier.
mul_q  output  WIDTH  operand Q to the multiplier.
mul_start  output  1  one-cycle start pulse to the multiplier.
mul_result  input  2*WIDTH  multiplier product.

Behaviour:
- All outputs are registered.
- Reset (n_rst=0 at a clk edge) sets gnt, done, mul_start, busy, mul_m, mul_q and rsp_result to 0. It also sets state to IDLE, the round-robin pointer ptr to 0, owner to 0 and cnt to 0.
- FSM has two states: IDLE and WAIT.
- IDLE with req==0: hold state; gnt, done and mul_start are 0.
- IDLE with req!=0: select the first set req bit scanning ptr, ptr+1, ... NREQ-1, 0, ... (wrap-around). At that edge:
  - gnt[i]<=1 and mul_start<=1.
  - mul_m<=req_m slice i and mul_q<=req_q slice i.
  - owner<=i, cnt<=MUL_LAT, busy<=1, state<=WAIT.
  - This edge begins cycle S, in which mul_start=1.
- WAIT: gnt and mul_start return to 0 after one cycle. mul_m and mul_q hold for the whole WAIT period. cnt decrements once per cycle.
- WAIT at the edge where cnt==1 (ending cycle S+MUL_LAT-1) and cnt continues to decrement: at the edge ending cycle S+MUL_LAT:
  - rsp_result<=mul_result and done[owner]<=1.
  - busy<=0, ptr<=(owner+1) mod NREQ, state<=IDLE.
- Timing consequences:
  - done and rsp_result are valid in cycle S+MUL_LAT+1.
  - rsp_result holds until the next done.
  - The earliest next gnt/mul_start is cycle S+MUL_LAT+2, so peak throughput is one product per MUL_LAT+2 cycles.
- req is sampled only in IDLE. Requests that rise during WAIT wait; none are lost or queued beyond their req level.
- A requester drops req in the cycle after seeing gnt. If req is still high after gnt, it counts as a new request.
- A requester dropping req before gnt withdraws the request. req changing during WAIT has no effect on the in-flight operation.
- Fairness: a continuously requesting set is served in strict rotation. No requester waits more than NREQ-1 operations.
- Reset mid-operation (in WAIT): next edge returns to IDLE with all outputs 0. The in-flight result is discarded, and no done is issued for it.
- Product width is 2*WIDTH. The arbiter passes mul_result through unmodified; it does no sign handling of its own.
- Simultaneous done and a new req: done is issued; the new grant follows one cycle later, from IDLE.

Test Plan:
- Reset: hold n_rst=0 for 2 edges with random req -> all outputs 0, no gnt; first gnt goes to the lowest set req index after release.
- Single op: req[0]=1, M=6'b110100 (-12), Q=6'b011110 (30), MUL_LAT=8 -> exactly one gnt[0] and one mul_start pulse in the same cycle; mul_m=6'b110100 and mul_q=6'b011110 hold through WAIT; done[0] appears exactly 9 cycles after mul_start; rsp_result=12'hE98 (-360).
- Full contention: req=4'b1111 from reset with distinct operands (1*1, 2*-3, -32*-32, 31*-1) -> grants in order 0,1,2,3, spaced 10 cycles apart; products 12'h001, 12'hFFA, 12'h400, 12'hFE1, each paired with the correct done bit.
- Round-robin wrap: req[3] and req[1] held high continuously after a grant to 3 -> grant order 1,3,1,3; ptr wraps from 3 to 0.
- Reset in WAIT: deassert n_rst 4 cycles after mul_start -> no done pulse; busy=0 next cycle; the pending req is re-granted after release starting from index 0.
- Late request and minimum latency: req[2] rises while busy=1 -> no gnt until IDLE. Rebuild with MUL_LAT=1 -> done arrives 2 cycles after mul_start with the correct product.
